dma_stream_tester: RTL and testbench

- Parametrised successor to the single-channel DMA loopback tester.
- Generates AXI-Stream packets into the DMA S2MM input (dat1_i) and checks packets returned from the DMA MM2S output (dat0_o).
- Generalised in data width and channel count; packets are spread round-robin over tdest channels, with a selectable incrementing or LFSR pattern.
- Reports error counts and flags, and exposes beat/packet status for software or bench observation.

---
 rtl/dma_stream_tester_if.sv | 15 +
 rtl/dma_stream_tester.sv | 203 ++++++++++++++++++++
 tb/tb_dma_stream_tester.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_stream_tester_if.sv
// AXI-Stream bundle used for both the generator (master) and checker (slave) sides
// of dma_stream_tester.
interface dma_stream_tester_if #(
  parameter int DW = 32
);
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [3:0]      tdest;
  logic            tlast;

  modport master (output tvalid, tdata, tkeep, tdest, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tdest, tlast, output tready);
endinterface

// File: rtl/dma_stream_tester.sv
// Multi-channel AXI-Stream DMA loopback tester: round-robin tdest packet generator plus checker.
// Optional DMA_STREAM_TESTER_THROTTLE_EN adds LFSR-driven gen gaps and chk_tready backpressure.
module dma_stream_tester_lane #(
  parameter int L = 1,
  parameter int J = 0
) (
  input  logic        mode,
  input  logic [3:0]  ch,
  input  logic [31:0] seq,
  input  logic [31:0] lfsr,
  output logic [31:0] lane
);
  localparam logic [31:0] LJ = 32'(J);
  localparam logic [31:0] LL = 32'(L);

  always_comb begin
    if (mode) lane = lfsr ^ (32'h1111_1111 * LJ);
    else      lane = (seq * LL + LJ) ^ {ch, 28'b0};
  end
endmodule

module dma_stream_tester #(
  parameter int DW   = 32,
  parameter int NCH  = 4,
  parameter int LENW = 16,
  parameter int ERRW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_mode,
  input  logic [LENW-1:0]  cfg_pkt_len,
  input  logic [15:0]      cfg_pkt_cnt,
  dma_stream_tester_if.master gen,
  dma_stream_tester_if.slave  chk,
  output logic             sts_busy,
  output logic             sts_done,
  output logic [ERRW-1:0]  sts_err_cnt,
  output logic [3:0]       sts_err_flags,
  output logic [15:0]      sts_tx_pkts,
  output logic [15:0]      sts_rx_pkts
);
  localparam int L = DW / 32;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0000;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
  endfunction

  logic [1:0]            state;
  logic                  mode;
  logic [LENW-1:0]       len_m1;
  logic [15:0]           pkt_cnt;
  logic                  gen_vld, rdy_en, gap;
  logic [LENW-1:0]       gen_beat;
  logic [3:0]            gen_ch;
  logic [NCH-1:0][31:0]  gen_seq, gen_lfsr, chk_seq, chk_lfsr;
  logic [NCH-1:0][LENW-1:0] chk_beat;
  logic [31:0]           g_seq, g_lfsr, c_seq, c_lfsr;
  logic [LENW-1:0]       c_beat;
  logic                  c_in;
  logic [L-1:0][31:0]    g_lane, c_lane;

  wire run      = (state == S_RUN);
  wire start_ok = cfg_start && !run;
  wire gen_hs   = gen_vld && gen.tready;
  wire gen_last = (gen_beat == len_m1);
  wire tx_fin   = gen_last && (sts_tx_pkts + 16'd1 == pkt_cnt);
  wire chk_hs   = run && chk.tvalid && chk.tready;
  wire c_last   = (c_beat == len_m1);
  wire e_data   = c_in && (c_lane != chk.tdata);
  wire e_keep   = (chk.tkeep != '1);
  wire e_last   = c_in && (chk.tlast != c_last);
  wire e_dest   = !c_in;
  wire beat_err = e_data | e_keep | e_last | e_dest;

  assign sts_busy = run;

  // Per-channel state selected by the generator's channel and by the incoming tdest.
  always_comb begin
    g_seq = '0; g_lfsr = '0; c_seq = '0; c_lfsr = '0; c_beat = '0; c_in = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (gen_ch == 4'(c)) begin
        g_seq  = gen_seq[c];
        g_lfsr = gen_lfsr[c];
      end
      if (chk.tdest == 4'(c)) begin
        c_seq  = chk_seq[c];
        c_lfsr = chk_lfsr[c];
        c_beat = chk_beat[c];
        c_in   = 1'b1;
      end
    end
  end

  for (genvar j = 0; j < L; j++) begin : g_lanes
    dma_stream_tester_lane #(.L(L), .J(j)) u_gen (
      .mode(mode), .ch(gen_ch), .seq(g_seq), .lfsr(g_lfsr), .lane(g_lane[j]));
    dma_stream_tester_lane #(.L(L), .J(j)) u_chk (
      .mode(mode), .ch(chk.tdest), .seq(c_seq), .lfsr(c_lfsr), .lane(c_lane[j]));
  end

  // Payload is zeroed while idle so all outputs read 0 in and after reset.
  assign gen.tvalid = gen_vld;
  assign gen.tdata  = gen_vld ? g_lane : '0;
  assign gen.tkeep  = {(DW/8){gen_vld}};
  assign gen.tdest  = gen_vld ? gen_ch : 4'd0;
  assign gen.tlast  = gen_vld & gen_last;

`ifdef DMA_STREAM_TESTER_THROTTLE_EN
  logic [15:0] thr_lfsr;
  always_ff @(posedge clk) begin
    if (reset) thr_lfsr <= 16'hBEEF;
    else       thr_lfsr <= thr_lfsr[0] ? ((thr_lfsr >> 1) ^ 16'hB400) : (thr_lfsr >> 1);
  end
  assign gap        = thr_lfsr[5];
  assign chk.tready = rdy_en & (thr_lfsr[0] | thr_lfsr[3]);
`else
  assign gap        = 1'b0;
  assign chk.tready = rdy_en;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mode     <= 1'b0;
      len_m1   <= '0;
      pkt_cnt  <= '0;
      gen_vld  <= 1'b0;
      sts_done <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (run) begin
        if (sts_tx_pkts == pkt_cnt && sts_rx_pkts == pkt_cnt) begin
          state    <= S_DONE;
          sts_done <= 1'b1;
        end
        // A raised tvalid is only re-evaluated at its handshake, so it never drops early.
        if (!gen_vld || gen_hs)
          gen_vld <= !gap && (gen_hs ? !tx_fin : (sts_tx_pkts != pkt_cnt));
      end else if (cfg_start) begin
        state    <= S_RUN;
        mode     <= cfg_mode;
        len_m1   <= (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - 1'b1;
        pkt_cnt  <= cfg_pkt_cnt;
        sts_done <= 1'b0;
        gen_vld  <= (cfg_pkt_cnt != '0) && !gap;
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      gen_beat      <= '0;
      gen_ch        <= '0;
      sts_tx_pkts   <= '0;
      sts_rx_pkts   <= '0;
      sts_err_cnt   <= '0;
      sts_err_flags <= '0;
      for (int c = 0; c < NCH; c++) begin
        gen_seq[c]  <= '0;
        gen_lfsr[c] <= LFSR_SEED | 32'(c);
        chk_seq[c]  <= '0;
        chk_lfsr[c] <= LFSR_SEED | 32'(c);
        chk_beat[c] <= '0;
      end
    end else begin
      if (gen_hs) begin
        gen_beat <= gen_last ? '0 : gen_beat + 1'b1;
        if (gen_last) begin
          sts_tx_pkts <= sts_tx_pkts + 16'd1;
          gen_ch      <= (gen_ch == 4'(NCH - 1)) ? 4'd0 : gen_ch + 4'd1;
        end
        for (int c = 0; c < NCH; c++) begin
          if (gen_ch == 4'(c)) begin
            gen_seq[c]  <= g_seq + 32'd1;
            gen_lfsr[c] <= lfsr_step(g_lfsr);
          end
        end
      end
      if (chk_hs) begin
        if (beat_err) begin
          sts_err_flags <= sts_err_flags | {e_dest, e_keep, e_last, e_data};
          if (sts_err_cnt != '1) sts_err_cnt <= sts_err_cnt + 1'b1;
        end
        // Expected state follows every in-range beat, good or bad, so one bad beat costs one error.
        for (int c = 0; c < NCH; c++) begin
          if (chk.tdest == 4'(c)) begin
            chk_seq[c]  <= c_seq + 32'd1;
            chk_lfsr[c] <= lfsr_step(c_lfsr);
            chk_beat[c] <= c_last ? '0 : c_beat + 1'b1;
          end
        end
        if (c_in && c_last) sts_rx_pkts <= sts_rx_pkts + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_dma_stream_tester.sv
// Directed bench for dma_stream_tester: a table of loopback runs plus hand-written
// sequences for count 0, out-of-range tdest, mid-run reset and a 128-bit instance.
`timescale 1ns/1ps
module tb_dma_stream_tester;
  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_start, b_start, cfg_mode;
  logic [15:0] cfg_pkt_len, cfg_pkt_cnt;

  int n_vec = 0, n_bad = 0;

  // ---------------- DUT A: DW=32 ----------------
  dma_stream_tester_if #(.DW(32)) a_gen ();
  dma_stream_tester_if #(.DW(32)) a_chk ();
  logic        a_busy, a_done;
  logic [15:0] a_err, a_tx, a_rx;
  logic [3:0]  a_flags;

  dma_stream_tester #(.DW(32), .NCH(NCH)) u_a (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_cnt(cfg_pkt_cnt),
    .gen(a_gen), .chk(a_chk),
    .sts_busy(a_busy), .sts_done(a_done), .sts_err_cnt(a_err),
    .sts_err_flags(a_flags), .sts_tx_pkts(a_tx), .sts_rx_pkts(a_rx));

  // Loopback with optional bit-0 corruption, or a manual checker drive (gen then sinks freely).
  logic        man, m_tvalid, m_tlast;
  logic [3:0]  m_tdest;
  logic [31:0] m_tdata, flip;
  int          flip_beat = -1;
  int          hs_cnt = 0;

  assign flip          = (flip_beat >= 0 && hs_cnt == flip_beat) ? 32'h1 : 32'h0;
  assign a_gen.tready  = man ? 1'b1 : a_chk.tready;
  assign a_chk.tvalid  = man ? m_tvalid : a_gen.tvalid;
  assign a_chk.tdata   = man ? m_tdata : (a_gen.tdata ^ flip);
  assign a_chk.tkeep   = man ? 4'hF : a_gen.tkeep;
  assign a_chk.tdest   = man ? m_tdest : a_gen.tdest;
  assign a_chk.tlast   = man ? m_tlast : a_gen.tlast;

  // ---------------- DUT B: DW=128, plain loopback ----------------
  dma_stream_tester_if #(.DW(128)) b_gen ();
  dma_stream_tester_if #(.DW(128)) b_chk ();
  logic        b_busy, b_done;
  logic [15:0] b_err, b_tx, b_rx;
  logic [3:0]  b_flags;

  dma_stream_tester #(.DW(128), .NCH(NCH)) u_b (
    .clk(clk), .reset(reset), .cfg_start(b_start), .cfg_mode(cfg_mode),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_cnt(cfg_pkt_cnt),
    .gen(b_gen), .chk(b_chk),
    .sts_busy(b_busy), .sts_done(b_done), .sts_err_cnt(b_err),
    .sts_err_flags(b_flags), .sts_tx_pkts(b_tx), .sts_rx_pkts(b_rx));

  assign b_gen.tready = b_chk.tready;
  assign b_chk.tvalid = b_gen.tvalid;
  assign b_chk.tdata  = b_gen.tdata;
  assign b_chk.tkeep  = b_gen.tkeep;
  assign b_chk.tdest  = b_gen.tdest;
  assign b_chk.tlast  = b_gen.tlast;

  // ---------------- reference model of DUT A's generator ----------------
  function automatic logic [31:0] lstep(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  logic        mon_clr = 1'b0, cur_mode = 1'b0;
  int          cur_len = 1;
  logic [31:0] m_seq [NCH];
  logic [31:0] m_lfsr[NCH];
  int          m_beat = 0, m_pkt = 0, tlast_cnt = 0, bad_beats = 0;
  logic [31:0] first0 = '0, first1 = '0;
  logic        seen0 = 1'b0, seen1 = 1'b0;

  function automatic logic [31:0] mexp(input int c);
    return cur_mode ? m_lfsr[c] : (m_seq[c] ^ (32'(c) << 28));
  endfunction

  always @(posedge clk) begin
    if (mon_clr) begin
      hs_cnt <= 0; tlast_cnt <= 0; bad_beats <= 0; m_beat <= 0; m_pkt <= 0;
      seen0 <= 1'b0; seen1 <= 1'b0; first0 <= '0; first1 <= '0;
      for (int c = 0; c < NCH; c++) begin
        m_seq[c]  <= '0;
        m_lfsr[c] <= 32'hACE1_0000 | 32'(c);
      end
    end else if (a_gen.tvalid && a_gen.tready) begin
      hs_cnt <= hs_cnt + 1;
      if (a_gen.tdest != 4'(m_pkt % NCH) || a_gen.tdata != mexp(m_pkt % NCH) ||
          a_gen.tkeep != 4'hF || a_gen.tlast != (m_beat == cur_len - 1))
        bad_beats <= bad_beats + 1;
      if (a_gen.tlast) tlast_cnt <= tlast_cnt + 1;
      m_seq[m_pkt % NCH]  <= m_seq[m_pkt % NCH] + 32'd1;
      m_lfsr[m_pkt % NCH] <= lstep(m_lfsr[m_pkt % NCH]);
      if (m_beat == cur_len - 1) begin
        m_beat <= 0;
        m_pkt  <= m_pkt + 1;
      end else begin
        m_beat <= m_beat + 1;
      end
      if (!seen0 && a_gen.tdest == 4'd0) begin first0 <= a_gen.tdata; seen0 <= 1'b1; end
      if (!seen1 && a_gen.tdest == 4'd1) begin first1 <= a_gen.tdata; seen1 <= 1'b1; end
    end
  end

  int           b_beats = 0, b_tlast = 0;
  logic [127:0] b_first0 = '0, b_first1 = '0;
  logic         b_seen0 = 1'b0, b_seen1 = 1'b0;

  always @(posedge clk) begin
    if (b_start) begin
      b_beats <= 0; b_tlast <= 0; b_seen0 <= 1'b0; b_seen1 <= 1'b0;
    end else if (b_gen.tvalid && b_gen.tready) begin
      b_beats <= b_beats + 1;
      if (b_gen.tlast) b_tlast <= b_tlast + 1;
      if (!b_seen0 && b_gen.tdest == 4'd0) begin b_first0 <= b_gen.tdata; b_seen0 <= 1'b1; end
      if (!b_seen1 && b_gen.tdest == 4'd1) begin b_first1 <= b_gen.tdata; b_seen1 <= 1'b1; end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_a(input logic mode, input logic [15:0] len, input logic [15:0] cnt);
    @(negedge clk);
    cfg_mode = mode; cfg_pkt_len = len; cfg_pkt_cnt = cnt;
    cur_mode = mode; cur_len = (len == 16'd0) ? 1 : int'(len);
    cfg_start = 1'b1; mon_clr = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_a(input int budget, input string nm);
    int k = 0;
    while (!a_done && k < budget) begin @(negedge clk); k++; end
    check(nm, a_done, 1'b1);
  endtask

  task automatic send_man(input logic [3:0] d, input logic [31:0] data, input logic last);
    int k = 0;
    m_tvalid = 1'b1; m_tdest = d; m_tdata = data; m_tlast = last;
    while (!a_chk.tready && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    m_tvalid = 1'b0;
    check("man_hs_bound", k < 100, 1'b1);
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] len;
    logic [15:0] cnt;
    int          flip_beat;
    logic        poke;
    logic [15:0] e_err;
    logic [3:0]  e_flags;
    logic [31:0] e_first0;
    logic [31:0] e_first1;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input int i);
    flip_beat = vt[i].flip_beat;
    start_a(vt[i].mode, vt[i].len, vt[i].cnt);
    if (vt[i].poke) begin
      repeat (20) @(negedge clk);
      check($sformatf("v%0d_busy_mid", i), a_busy, 1'b1);
      cfg_pkt_cnt = 16'd0; cfg_mode = ~vt[i].mode; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0; cfg_pkt_cnt = vt[i].cnt; cfg_mode = vt[i].mode;
    end
    wait_a(3000, $sformatf("v%0d_done", i));
    flip_beat = -1;
    check($sformatf("v%0d_busy", i),   a_busy, 1'b0);
    check($sformatf("v%0d_tx", i),     a_tx, vt[i].cnt);
    check($sformatf("v%0d_rx", i),     a_rx, vt[i].cnt);
    check($sformatf("v%0d_err", i),    a_err, vt[i].e_err);
    check($sformatf("v%0d_flags", i),  a_flags, vt[i].e_flags);
    check($sformatf("v%0d_first0", i), first0, vt[i].e_first0);
    check($sformatf("v%0d_first1", i), first1, vt[i].e_first1);
    check($sformatf("v%0d_tlasts", i), tlast_cnt, vt[i].cnt);
    check($sformatf("v%0d_model", i),  bad_beats, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            mode  len    cnt   flip poke err    flags  first0          first1
    vt[0] = '{1'b0, 16'd16, 16'd8, -1, 1'b1, 16'd0, 4'h0, 32'h0000_0000, 32'h1000_0000};
    vt[1] = '{1'b1, 16'd3,  16'd5, -1, 1'b0, 16'd0, 4'h0, 32'hACE1_0000, 32'hACE1_0001};
    vt[2] = '{1'b0, 16'd16, 16'd8,  5, 1'b0, 16'd1, 4'h1, 32'h0000_0000, 32'h1000_0000};
    vt[3] = '{1'b0, 16'd0,  16'd4, -1, 1'b0, 16'd0, 4'h0, 32'h0000_0000, 32'h1000_0000};
    vt[4] = '{1'b1, 16'd2,  16'd6,  7, 1'b0, 16'd1, 4'h1, 32'hACE1_0000, 32'hACE1_0001};
    vt[5] = '{1'b0, 16'd5,  16'd3, -1, 1'b0, 16'd0, 4'h0, 32'h0000_0000, 32'h1000_0000};

    reset = 1'b1; cfg_start = 1'b0; b_start = 1'b0; cfg_mode = 1'b0;
    cfg_pkt_len = 16'd1; cfg_pkt_cnt = 16'd0;
    man = 1'b0; m_tvalid = 1'b0; m_tlast = 1'b0; m_tdest = 4'd0; m_tdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tready", a_chk.tready, 1'b0);
    check("rst_tvalid", a_gen.tvalid, 1'b0);
    check("rst_tdata",  a_gen.tdata, 32'h0);
    check("rst_tlast",  a_gen.tlast, 1'b0);
    check("rst_busy",   a_busy, 1'b0);
    check("rst_done",   a_done, 1'b0);
    check("rst_err",    a_err, 16'd0);
    check("rst_tx",     a_tx, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_tready", a_chk.tready, 1'b1);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Packet count of zero: done one cycle after start, no beats
    start_a(1'b0, 16'd4, 16'd0);
    check("cnt0_busy",   a_busy, 1'b1);
    check("cnt0_tvalid", a_gen.tvalid, 1'b0);
    check("cnt0_done0",  a_done, 1'b0);
    @(negedge clk);
    check("cnt0_done1",  a_done, 1'b1);
    check("cnt0_idle",   a_busy, 1'b0);
    check("cnt0_beats",  hs_cnt, 0);

    // Out-of-range tdest touches no channel: 7 and 4 are both flagged, ch0 then checks clean
    man = 1'b1;
    start_a(1'b0, 16'd2, 16'd1);
    send_man(4'd7, 32'h0, 1'b0);
    check("dest7_err",   a_err, 16'd1);
    check("dest7_flags", a_flags, 4'h8);
    send_man(4'd4, 32'h0, 1'b0);
    check("dest4_err",   a_err, 16'd2);
    send_man(4'd0, 32'h0, 1'b0);
    send_man(4'd0, 32'h1, 1'b1);
    wait_a(100, "dest_done");
    check("dest_err_final", a_err, 16'd2);
    check("dest_flags_fin", a_flags, 4'h8);
    check("dest_rx",        a_rx, 16'd1);
    man = 1'b0;

    // Reset during beat 3 of packet 2 aborts immediately
    start_a(1'b0, 16'd4, 16'd4);
    begin
      int k = 0;
      while (hs_cnt != 11 && k < 500) begin @(negedge clk); k++; end
      check("mid_reach", hs_cnt, 11);
    end
    check("mid_tx", a_tx, 16'd2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy",   a_busy, 1'b0);
    check("mid_done",   a_done, 1'b0);
    check("mid_tx0",    a_tx, 16'd0);
    check("mid_rx0",    a_rx, 16'd0);
    check("mid_err0",   a_err, 16'd0);
    check("mid_tvalid", a_gen.tvalid, 1'b0);
    check("mid_tready", a_chk.tready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    run_vec(0);

    // 128-bit instance, LFSR mode, single-beat packets
    @(negedge clk);
    cfg_mode = 1'b1; cfg_pkt_len = 16'd1; cfg_pkt_cnt = 16'd4; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    begin
      int k = 0;
      while (!b_done && k < 500) begin @(negedge clk); k++; end
    end
    check("b_done",   b_done, 1'b1);
    check("b_tx",     b_tx, 16'd4);
    check("b_rx",     b_rx, 16'd4);
    check("b_err",    b_err, 16'd0);
    check("b_beats",  b_beats, 4);
    check("b_tlasts", b_tlast, 4);
    check("b_first0", b_first0, 128'h9FD23333_8EC32222_BDF01111_ACE10000);
    check("b_first1", b_first1, 128'h9FD23332_8EC32223_BDF01110_ACE10001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
